uart_tx_responder: RTL and testbench

UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

---
 rtl/uart_tx_responder_if.sv | 22 ++
 rtl/uart_tx_responder.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_responder_if.sv
// Wishbone classic slave bundle for the UART transmit responder.
// The bus master drives the request side; the responder returns data and acknowledge.
interface uart_tx_responder_if;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_addr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_addr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/uart_tx_responder.sv
// Wishbone-programmable UART transmitter: byte FIFO feeding an 8N1 serialiser
// with a runtime divisor, line status and a transmit-empty interrupt.
module uart_tx_responder #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RST    = 16'd15
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    uart_tx_responder_if.slave  wb,
    output logic                int_o,
    output logic                baud_o,
    output logic                stx_pad_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q, state_d;
    logic           ack_q, ack_d;
    logic           rst_done_q, rst_done_d;
    logic [15:0]    div_q, div_d;
    logic           ier_q, ier_d;
    logic           ovr_q, ovr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           stx_q, stx_d;
    logic           baud_q, baud_d;
    logic           int_q, int_d;

    logic [7:0]     mem [FIFO_DEPTH];

    logic           req, bus_wr, bus_rd, empty, full, thre, temt;
    logic           thr_wr, push, ovf, flush, lsr_rd, pop;
    logic [2:0]     reg_sel;
    logic [31:0]    rdata;
    logic           unused_bits;

    assign unused_bits = ^{wb.wb_dat_i[31:16], wb.wb_addr_i[1:0], wb.wb_sel_i[3:2]};

    // All register side effects happen in the ack cycle, while the master still holds the request.
    assign req     = wb.wb_cyc_i & wb.wb_stb_i;
    assign bus_wr  = ack_q & wb.wb_we_i;
    assign bus_rd  = ack_q & ~wb.wb_we_i;
    assign reg_sel = wb.wb_addr_i[4:2];
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign thre    = empty;
    assign temt    = empty & (state_q == S_IDLE);
    assign thr_wr  = bus_wr & (reg_sel == 3'd0) & wb.wb_sel_i[0];
    assign push    = thr_wr & ~full;
    assign ovf     = thr_wr & full;
    assign flush   = bus_wr & (reg_sel == 3'd4) & wb.wb_sel_i[0] & wb.wb_dat_i[1];
    assign lsr_rd  = bus_rd & (reg_sel == 3'd3);
    assign pop     = (state_q == S_IDLE) & ~empty;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd1:    rdata = {16'd0, div_q};
            3'd2:    rdata = {31'd0, ier_q};
            3'd3:    rdata = {25'd0, temt, thre, 3'b000, ovr_q, full};
            default: rdata = '0;
        endcase
    end

    assign wb.wb_dat_o = ack_q ? rdata : 32'd0;
    assign wb.wb_ack_o = ack_q;

    always_comb begin
        state_d    = state_q;
        rst_done_d = 1'b1;
        ack_d      = req & ~ack_q & rst_done_q;
        div_d      = div_q;
        ier_d      = ier_q;
        ovr_d      = (ovr_q & ~lsr_rd) | ovf;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (bus_wr && reg_sel == 3'd1) begin
            if (wb.wb_sel_i[0]) div_d[7:0]  = wb.wb_dat_i[7:0];
            if (wb.wb_sel_i[1]) div_d[15:8] = wb.wb_dat_i[15:8];
        end
        if (bus_wr && reg_sel == 3'd2 && wb.wb_sel_i[0]) ier_d = wb.wb_dat_i[0];

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flushing realigns the read side to the write side, discarding a same-cycle pop too.
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    cnt_d   = div_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d     = div_q;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 16'd1;
            end
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        case (state_d)
            S_START: stx_d = 1'b0;
            S_DATA:  stx_d = shift_d[0];
            default: stx_d = 1'b1;
        endcase
        baud_d = (state_d != S_IDLE) && (cnt_d == '0);
        int_d  = ier_q & empty;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            rst_done_q <= 1'b0;
            div_q      <= DIV_RST;
            ier_q      <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stx_q      <= 1'b1;
            baud_q     <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rst_done_q <= rst_done_d;
            div_q      <= div_d;
            ier_q      <= ier_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stx_q      <= stx_d;
            baud_q     <= baud_d;
            int_q      <= int_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && push) mem[wr_ptr_q] <= wb.wb_dat_i[7:0];
    end

    assign stx_pad_o = stx_q;
    assign baud_o    = baud_q;
    assign int_o     = int_q;
endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench: bus transactions plus a serial-line receiver model that
// decodes every frame and compares it with the queue of bytes the bus accepted.
module tb_uart_tx_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic int_o, baud_o, stx;

    always #5 clk = ~clk;

    uart_tx_responder_if bus();

    uart_tx_responder #(.FIFO_DEPTH(16), .DIV_RST(16'd15)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wb        (bus.slave),
        .int_o     (int_o),
        .baud_o    (baud_o),
        .stx_pad_o (stx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model state
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;
    int         mon_bit = -1;
    int         frames = 0;
    int         idle_baud_errs = 0;
    int         div_model = 15;
    int         mon_len;
    logic [9:0] mon_bits;
    bit         mon_shape;
    int         mon_bauds;
    logic [7:0] mon_exp;

    always begin
        @(negedge clk);
        if (mon_en && stx === 1'b0) begin
            mon_busy  = 1'b1;
            mon_len   = div_model + 1;
            mon_shape = 1'b1;
            mon_bauds = 0;
            for (int b = 0; b < 10; b++) begin
                mon_bit = b;
                for (int c = 0; c < mon_len; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (c == 0) mon_bits[b] = stx;
                    else if (stx !== mon_bits[b]) mon_shape = 1'b0;
                    if (baud_o === 1'b1) begin
                        mon_bauds++;
                        if (c != mon_len - 1) mon_shape = 1'b0;
                    end
                end
            end
            mon_bit = -1;
            frames++;
            if (exp_q.size() == 0) begin
                check_val("frame_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, mon_exp});
            end
            check_val("frame_start_stop", {30'd0, mon_bits[9], mon_bits[0]}, 32'd2);
            check_val("frame_shape", {31'd0, mon_shape}, 32'd1);
            check_val("frame_baud", mon_bauds, 32'd10);
            $display("frame %0d: data=0x%02h bit_len=%0d bauds=%0d", frames, mon_bits[8:1], mon_len, mon_bauds);
            mon_busy = 1'b0;
        end else if (mon_en && baud_o === 1'b1) begin
            idle_baud_errs++;
        end
    end

    task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdat,
                            input logic [3:0] sel, output logic [31:0] rdat);
        int n = 0;
        @(negedge clk);
        bus.wb_addr_i = addr;
        bus.wb_dat_i  = wdat;
        bus.wb_sel_i  = sel;
        bus.wb_we_i   = we;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wb_ack_o !== 1'b1 && n < 20);
        if (bus.wb_ack_o !== 1'b1) check_val("ack_timeout", 32'd0, 32'd1);
        rdat = bus.wb_dat_o;
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        $display("%s addr=%0d data=0x%0h sel=%b", we ? "wr" : "rd", addr[4:2],
                 we ? wdat : rdat, sel);
    endtask

    task automatic wb_wr(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        bus_xfer(1'b1, addr, d, sel, dummy);
    endtask

    task automatic wb_rd(input logic [4:0] addr, output logic [31:0] d);
        bus_xfer(1'b0, addr, 32'd0, 4'b1111, d);
    endtask

    task automatic set_div(input int d);
        wb_wr(5'h04, d, 4'b0011);
        div_model = d;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wb_wr(5'h00, {24'd0, b}, 4'b0001);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_done", {31'd0, (n < bound)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [7:0]  keep;
    int          n_bytes, d, f0, lows, cyc;

    initial begin
        bus.wb_addr_i = '0;
        bus.wb_dat_i  = '0;
        bus.wb_sel_i  = '0;
        bus.wb_we_i   = 1'b0;
        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_stx", {31'd0, stx}, 32'd1);
        check_val("rst_baud", {31'd0, baud_o}, 32'd0);
        check_val("rst_int", {31'd0, int_o}, 32'd0);
        check_val("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Reset values and register map
        wb_rd(5'h0C, rd); check_val("lsr_reset", rd, 32'h60);
        @(negedge clk);
        check_val("dat_o_idle", bus.wb_dat_o, 32'd0);
        wb_rd(5'h04, rd); check_val("div_reset", rd, 32'h000F);
        check_val("int_reset", {31'd0, int_o}, 32'd0);
        wb_wr(5'h04, 32'h1234, 4'b0011);
        wb_wr(5'h04, 32'hABCD, 4'b0010);
        wb_rd(5'h04, rd); check_val("div_byte_en", rd, 32'hAB34);
        wb_wr(5'h08, 32'hFF, 4'b0001);
        wb_rd(5'h08, rd); check_val("ier_rw", rd, 32'h1);
        wb_wr(5'h08, 32'h0, 4'b0001);
        wb_rd(5'h14, rd); check_val("unmapped_read", rd, 32'h0);
        wb_rd(5'h00, rd); check_val("thr_read", rd, 32'h0);

        // 0xA5 at four cycles per bit
        set_div(3);
        push_byte(8'hA5);
        wait_drain(200);
        wb_rd(5'h0C, rd); check_val("temt_after_frame", rd, 32'h60);

        // Overflow with a slow line so the FIFO cannot drain meanwhile
        set_div(100);
        for (int i = 0; i < 17; i++) push_byte(8'($urandom));
        wb_rd(5'h0C, rd); check_val("lsr_full", rd, 32'h01);
        wb_wr(5'h00, 32'h5A, 4'b0001);
        wb_rd(5'h0C, rd); check_val("lsr_ovr_set", rd, 32'h03);
        wb_rd(5'h0C, rd); check_val("lsr_ovr_clr", rd, 32'h01);
        wb_wr(5'h10, 32'h02, 4'b0001);
        keep = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);
        wb_rd(5'h0C, rd); check_val("lsr_after_flush", rd, 32'h20);
        wait_drain(2000);

        // Interrupt timing around a single push
        set_div(1);
        wb_wr(5'h08, 32'h1, 4'b0001);
        repeat (2) @(negedge clk);
        check_val("int_idle", {31'd0, int_o}, 32'd1);
        push_byte(8'h3C);
        @(negedge clk); check_val("int_ack_plus1", {31'd0, int_o}, 32'd1);
        @(negedge clk); check_val("int_ack_plus2", {31'd0, int_o}, 32'd0);
        @(negedge clk); check_val("int_after_pop", {31'd0, int_o}, 32'd1);
        wait_drain(200);
        wb_wr(5'h08, 32'h0, 4'b0001);

        // Flush mid DATA bit: only the frame on the wire completes
        set_div(7);
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        cyc = 0;
        while (mon_bit < 2 && cyc < 300) begin @(negedge clk); cyc++; end
        check_val("reached_data_bit", {31'd0, (mon_bit >= 2)}, 32'd1);
        f0 = frames;
        wb_wr(5'h10, 32'h02, 4'b0001);
        keep = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);
        wait_drain(400);
        lows = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (stx !== 1'b1) lows++; end
        check_val("flush_frames", frames - f0, 32'd1);
        check_val("flush_line_idle", lows, 32'd0);
        wb_rd(5'h0C, rd); check_val("lsr_flushed", rd, 32'h60);

        // Randomized bursts with random divisors and gaps
        for (int it = 0; it < 8; it++) begin
            d = $urandom_range(0, 3);
            set_div(d);
            n_bytes = $urandom_range(1, 4);
            for (int k = 0; k < n_bytes; k++) begin
                if ($urandom_range(0, 4) == 0) wb_wr(5'h00, $urandom, 4'b0010);
                push_byte(8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drain(n_bytes * 11 * (d + 1) + 200);
            wb_rd(5'h0C, rd); check_val("lsr_rand_idle", rd, 32'h60);
        end

        // Reset mid-frame with a request held through reset
        mon_en = 1'b0;
        set_div(5);
        wb_wr(5'h00, 32'h81, 4'b0001);
        wb_wr(5'h00, 32'h7E, 4'b0001);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        bus.wb_addr_i = 5'h0C;
        bus.wb_we_i   = 1'b0;
        bus.wb_sel_i  = 4'b1111;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        @(negedge clk);
        check_val("rst_mid_stx", {31'd0, stx}, 32'd1);
        check_val("rst_mid_baud", {31'd0, baud_o}, 32'd0);
        check_val("rst_mid_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ack_held_after_rst", {31'd0, bus.wb_ack_o}, 32'd0);
        cyc = 0;
        while (bus.wb_ack_o !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        check_val("ack_after_rst", {31'd0, bus.wb_ack_o}, 32'd1);
        check_val("lsr_after_rst", bus.wb_dat_o, 32'h60);
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        div_model = 15;
        wb_rd(5'h04, rd); check_val("div_after_rst", rd, 32'h000F);
        lows = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (stx !== 1'b1) lows++; end
        check_val("line_idle_after_rst", lows, 32'd0);

        check_val("idle_baud", idle_baud_errs, 32'd0);
        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
